data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//  Responder end of the uDLX data-memory interface: serves load/store requests issued by the
//  memory-access stage, holds an on-chip word-organised data RAM, inserts configurable wait
//  states and returns read data with DLX byte/half/word extraction. Sits beside the MEM stage.
// PARAMETERS
//  DATA_WIDTH   32  word width (fixed at 32 for byte-lane logic)
//  ADDR_WIDTH   10  word-address bits; RAM depth = 2**ADDR_WIDTH words
//  WAIT_STATES  2   extra cycles between accept and response (0..15)
// PORTS
//  clk           in   1               clock
//  rst           in   1               asynchronous reset, active-high
//  req_valid     in   1               request present
//  req_wr        in   1               1=store, 0=load
//  req_addr      in   ADDR_WIDTH+2    byte address
//  req_size      in   2               00=byte, 01=half, 10=word, 11=reserved
//  req_unsigned  in   1               loads: 1=zero-extend, 0=sign-extend
//  req_wdata     in   DATA_WIDTH      store data, right-justified
//  req_ready     out  1               responder can accept
//  rsp_valid     out  1               one-cycle response strobe
//  rsp_rdata     out  DATA_WIDTH      extended load data; 0 for stores/errors
//  rsp_err       out  1               request rejected (misaligned/reserved size)
//  busy          out  1               request in flight (state != IDLE)
// BEHAVIOUR
//  - Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait count=0.
//    RAM contents are not reset. Reset mid-operation aborts it; a pending store is not written.
//  - Handshake: accept when req_valid && req_ready; req_ready=1 only in IDLE. Request fields are
//    latched on accept; later input changes are ignored until IDLE.
//  - FSM: IDLE -(accept, ok)-> WAIT (count=WAIT_STATES; skip to ACCESS if 0);
//    IDLE -(accept, error)-> RESP with rsp_err=1; WAIT: decrement, at 1 -> ACCESS;
//    ACCESS: RAM read/modify/write, -> RESP; RESP: rsp_valid=1 for exactly one cycle -> IDLE.
//  - Latency: accept at edge N -> rsp_valid high during cycle N+2+WAIT_STATES (ok),
//    N+1 (error). No back-pressure on response; the core stalls until rsp_valid.
//  - Big-endian lanes: byte offset 0 = bits[31:24], 3 = bits[7:0]; half offset 0 = [31:16].
//  - Word index = req_addr[ADDR_WIDTH+1:2]. Store byte/half merges into the addressed lanes
//    only; other lanes unchanged. Store rsp_rdata = 0.
//  - Load: selected lane right-justified, sign- or zero-extended per req_unsigned; word as-is.
//  - Error: half with addr[0]!=0, word with addr[1:0]!=0, or size 11 -> no RAM access,
//    rsp_err=1, rsp_rdata=0. rsp_err/rsp_rdata are valid only while rsp_valid=1, else 0.
//  - Back-to-back: next request accepted in the cycle after RESP (IDLE), never during RESP.
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN defined: misalignment/reserved-size detection as above.
//  Not defined: rsp_err tied 0; low address bits are forced to alignment (half: addr[0]=0,
//  word: addr[1:0]=0); size 11 treated as word; all requests take the normal path.
// TESTING (WAIT_STATES=2, DMEM_ALIGN_CHECK_EN defined)
//  1 SW 0xDEADBEEF @0x010, then LW @0x010 -> rsp_valid 4 cycles after each accept,
//    rdata=0xDEADBEEF, rsp_err=0.
//  2 SB 0x00000080 @0x011; LB @0x011 -> 0xFFFFFF80; LBU @0x011 -> 0x00000080;
//    LW @0x010 -> 0xDE80BEEF.
//  3 LH @0x012 -> 0xFFFFBEEF; LHU @0x012 -> 0x0000BEEF; SH 0x1234 @0x010 ->
//    LW 0x1234BEEF.
//  4 LW @0x012 -> rsp_valid+rsp_err 1 cycle after accept, rdata=0; SW @0x013 leaves RAM unchanged.
//  5 req_valid held high for 3 loads -> req_ready low while busy, responses spaced 5 cycles,
//    no request lost or duplicated.
//  6 SW 0x11111111 @0x020, assert rst in WAIT -> outputs at reset values next cycle;
//    LW @0x020 returns prior content.

Source files
------------

// File: rtl/data_memory_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory_responder_if
//  Purpose  : Request/response bundle between the uDLX MEM stage (master) and
//             the data-memory responder (slave).
//  Signals  : req_valid/req_wr/req_addr/req_size/req_unsigned/req_wdata are
//             driven by the master; req_ready/rsp_valid/rsp_rdata/rsp_err/busy
//             are driven by the responder.
//  Revision : 1.0  initial release
// ============================================================================
interface data_memory_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_wr;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_ready;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  busy;

  modport master (
    output req_valid, req_wr, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory_responder
//  Purpose  : Responder end of the uDLX data-memory interface. Accepts one
//             load/store at a time, inserts WAIT_STATES wait cycles, performs
//             a word-organised RAM read/modify/write with big-endian byte and
//             half-word lanes, and returns a one-cycle response strobe.
//  Ports    : clk  - clock
//             rst  - asynchronous reset, active-high
//             bus  - data_memory_responder_if.slave (request/response bundle)
//  Config   : DMEM_ALIGN_CHECK_EN - when defined, misaligned half/word and
//             reserved-size requests are rejected with rsp_err. When not
//             defined, low address bits are forced to alignment, size 11 is
//             treated as word and rsp_err is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module data_memory_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  data_memory_responder_if.slave   bus
);

  localparam int                    c_depth     = 2 ** ADDR_WIDTH;
  localparam logic [1:0]            c_size_byte = 2'b00;
  localparam logic [1:0]            c_size_half = 2'b01;
  localparam logic [1:0]            c_size_word = 2'b10;
  localparam logic [1:0]            c_size_rsvd = 2'b11;
  localparam logic [3:0]            c_wait_init = 4'(WAIT_STATES);
  localparam logic [DATA_WIDTH-1:0] c_byte_mask = DATA_WIDTH'(32'h0000_00FF);
  localparam logic [DATA_WIDTH-1:0] c_half_mask = DATA_WIDTH'(32'h0000_FFFF);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched request
  logic                  r_wr;
  logic [1:0]            r_size;
  logic [1:0]            r_off;
  logic                  r_unsigned;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [3:0]            r_wait_cnt;
  logic [DATA_WIDTH-1:0] r_rdata;

  // RAM
  logic [DATA_WIDTH-1:0] r_mem [c_depth];
  logic [DATA_WIDTH-1:0] r_rd_word;
  logic [ADDR_WIDTH-1:0] w_rd_idx;
  logic                  w_we;

  logic                  w_accept;
  logic                  w_req_err;
  logic [1:0]            w_norm_size;
  logic [1:0]            w_norm_off;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [7:0]            w_byte_lane;
  logic [15:0]           w_half_lane;
  logic [4:0]            w_lane_sh;

  assign w_accept = bus.req_valid && (r_state == S_IDLE);

  // --------------------------------------------------------------------------
  // Request classification / normalisation
  // --------------------------------------------------------------------------
  always_comb begin
    w_req_err   = 1'b0;
    w_norm_size = bus.req_size;
    w_norm_off  = bus.req_addr[1:0];
`ifdef DMEM_ALIGN_CHECK_EN
    case (bus.req_size)
      c_size_half: w_req_err = bus.req_addr[0];
      c_size_word: w_req_err = |bus.req_addr[1:0];
      c_size_rsvd: w_req_err = 1'b1;
      default:     w_req_err = 1'b0;
    endcase
`else
    case (bus.req_size)
      c_size_half: w_norm_off = {bus.req_addr[1], 1'b0};
      c_size_word,
      c_size_rsvd: begin
        w_norm_size = c_size_word;
        w_norm_off  = 2'b00;
      end
      default: w_norm_off = bus.req_addr[1:0];
    endcase
`endif
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err) begin
            w_state_nxt = S_RESP;
          end else if (WAIT_STATES == 0) begin
            w_state_nxt = S_ACCESS;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_wait_cnt <= 4'd1) begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch, wait counter and response data
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr       <= 1'b0;
      r_size     <= c_size_byte;
      r_off      <= 2'b00;
      r_unsigned <= 1'b0;
      r_wdata    <= '0;
      r_idx      <= '0;
      r_wait_cnt <= 4'd0;
      r_rdata    <= '0;
    end else begin
      if (w_accept) begin
        r_wr       <= bus.req_wr;
        r_size     <= w_norm_size;
        r_off      <= w_norm_off;
        r_unsigned <= bus.req_unsigned;
        r_wdata    <= bus.req_wdata;
        r_idx      <= bus.req_addr[ADDR_WIDTH+1:2];
        r_wait_cnt <= c_wait_init;
        r_rdata    <= '0;
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      if (r_state == S_ACCESS) begin
        r_rdata <= r_wr ? '0 : w_load;
      end
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_req_err;
    end
  end
  assign bus.rsp_err = (r_state == S_RESP) && r_err;
`else
  assign bus.rsp_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // RAM: synchronous read. On the accept edge the index comes straight from
  // the bus so the word is already available in ACCESS even with zero wait
  // states; afterwards the latched index keeps the read word current.
  // --------------------------------------------------------------------------
  assign w_rd_idx = w_accept ? bus.req_addr[ADDR_WIDTH+1:2] : r_idx;
  assign w_we     = (r_state == S_ACCESS) && r_wr;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_idx] <= w_merged;
    end
    r_rd_word <= r_mem[w_rd_idx];
  end

  // --------------------------------------------------------------------------
  // Big-endian lane extraction and store merge (offset 0 = most significant)
  // --------------------------------------------------------------------------
  always_comb begin
    w_byte_lane = r_rd_word[7:0];
    case (r_off)
      2'd0:    w_byte_lane = r_rd_word[31:24];
      2'd1:    w_byte_lane = r_rd_word[23:16];
      2'd2:    w_byte_lane = r_rd_word[15:8];
      default: w_byte_lane = r_rd_word[7:0];
    endcase
    w_half_lane = r_off[1] ? r_rd_word[15:0] : r_rd_word[31:16];

    case (r_size)
      c_size_byte: w_load = r_unsigned ? {{(DATA_WIDTH-8){1'b0}}, w_byte_lane}
                                       : {{(DATA_WIDTH-8){w_byte_lane[7]}}, w_byte_lane};
      c_size_half: w_load = r_unsigned ? {{(DATA_WIDTH-16){1'b0}}, w_half_lane}
                                       : {{(DATA_WIDTH-16){w_half_lane[15]}}, w_half_lane};
      default:     w_load = r_rd_word;
    endcase
  end

  always_comb begin
    w_lane_sh = 5'd0;
    w_merged  = r_wdata;
    case (r_size)
      c_size_byte: begin
        w_lane_sh = {~r_off, 3'b000};
        w_merged  = (r_rd_word & ~(c_byte_mask << w_lane_sh)) |
                    (({{(DATA_WIDTH-8){1'b0}}, r_wdata[7:0]}) << w_lane_sh);
      end
      c_size_half: begin
        w_lane_sh = r_off[1] ? 5'd0 : 5'd16;
        w_merged  = (r_rd_word & ~(c_half_mask << w_lane_sh)) |
                    (({{(DATA_WIDTH-16){1'b0}}, r_wdata[15:0]}) << w_lane_sh);
      end
      default: begin
        w_lane_sh = 5'd0;
        w_merged  = r_wdata;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: response fields are forced to zero outside the strobe cycle
  // --------------------------------------------------------------------------
  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_rdata = (r_state == S_RESP) ? r_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_data_memory_responder
//  Purpose  : Directed self-checking bench for data_memory_responder
//             (WAIT_STATES = 2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_memory_responder;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int WS = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  data_memory_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  data_memory_responder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .WAIT_STATES(WS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Issue one request and wait for its response. lat counts negedges from the
  // accept edge to the first negedge with rsp_valid high; -1 on timeout.
  task automatic do_req(input logic wr, input logic [AW+1:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_wr       = wr;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    rdata = 32'h0;
    err   = 1'b0;
    if (guard >= 50) begin
      bus.req_valid = 1'b0;
      lat = -1;
      return;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 50) begin
      lat = -1;
    end else begin
      rdata = bus.rsp_rdata;
      err   = bus.rsp_err;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0;
    bus.req_size = 2'b00; bus.req_unsigned = 1'b0; bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.rsp_rdata); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.rsp_err); end
    rst = 1'b0;
  endtask

  task automatic test_word;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 12'h010, 2'b10, 1'b0, 32'hDEADBEEF, rd, er, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL sw_latency: got %0d want 4", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sw_rdata: got %h want 00000000", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL sw_err: got %b want 0", er); end
    do_req(1'b0, 12'h010, 2'b10, 1'b0, 32'h0, rd, er, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL lw_latency: got %0d want 4", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h want deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err: got %b want 0", er); end
    // Strobe lasts one cycle and data returns to zero afterwards
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL lw_strobe_width: valid=%b rdata=%h want 0/0", bus.rsp_valid, bus.rsp_rdata);
    end
  endtask

  task automatic test_byte;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 12'h011, 2'b00, 1'b0, 32'h00000080, rd, er, lat);
    checks++; if (lat !== 4 || er !== 1'b0) begin errors++; $display("FAIL sb_resp: lat=%0d err=%b want 4/0", lat, er); end
    do_req(1'b0, 12'h011, 2'b00, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb: got %h want ffffff80", rd); end
    do_req(1'b0, 12'h011, 2'b00, 1'b1, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h want 00000080", rd); end
    do_req(1'b0, 12'h010, 2'b10, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDE80BEEF) begin errors++; $display("FAIL sb_merge: got %h want de80beef", rd); end
    do_req(1'b0, 12'h013, 2'b00, 1'b1, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h000000EF) begin errors++; $display("FAIL lbu_off3: got %h want 000000ef", rd); end
  endtask

  task automatic test_half;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 12'h012, 2'b01, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh: got %h want ffffbeef", rd); end
    do_req(1'b0, 12'h012, 2'b01, 1'b1, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL lhu: got %h want 0000beef", rd); end
    do_req(1'b1, 12'h010, 2'b01, 1'b0, 32'h00001234, rd, er, lat);
    checks++; if (lat !== 4 || rd !== 32'h0) begin errors++; $display("FAIL sh_resp: lat=%0d rdata=%h want 4/0", lat, rd); end
    do_req(1'b0, 12'h010, 2'b10, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h1234BEEF) begin errors++; $display("FAIL sh_merge: got %h want 1234beef", rd); end
  endtask

  task automatic test_align;
    logic [31:0] rd; logic er; int lat;
`ifdef DMEM_ALIGN_CHECK_EN
    do_req(1'b0, 12'h012, 2'b10, 1'b0, 32'h0, rd, er, lat);
    checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL lw_misaligned: lat=%0d err=%b rdata=%h want 1/1/0", lat, er, rd);
    end
    do_req(1'b1, 12'h013, 2'b10, 1'b0, 32'hA5A5A5A5, rd, er, lat);
    checks++; if (lat !== 1 || er !== 1'b1) begin errors++; $display("FAIL sw_misaligned: lat=%0d err=%b want 1/1", lat, er); end
    do_req(1'b0, 12'h010, 2'b10, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h1234BEEF) begin errors++; $display("FAIL ram_unchanged: got %h want 1234beef", rd); end
    do_req(1'b0, 12'h011, 2'b01, 1'b0, 32'h0, rd, er, lat);
    checks++; if (lat !== 1 || er !== 1'b1) begin errors++; $display("FAIL lh_misaligned: lat=%0d err=%b want 1/1", lat, er); end
    do_req(1'b0, 12'h010, 2'b11, 1'b0, 32'h0, rd, er, lat);
    checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL size_reserved: lat=%0d err=%b rdata=%h want 1/1/0", lat, er, rd);
    end
`else
    do_req(1'b0, 12'h012, 2'b10, 1'b0, 32'h0, rd, er, lat);
    checks++; if (lat !== 4 || er !== 1'b0 || rd !== 32'h1234BEEF) begin
      errors++; $display("FAIL lw_forced_align: lat=%0d err=%b rdata=%h want 4/0/1234beef", lat, er, rd);
    end
    do_req(1'b1, 12'h013, 2'b10, 1'b0, 32'hA5A5A5A5, rd, er, lat);
    checks++; if (lat !== 4 || er !== 1'b0) begin errors++; $display("FAIL sw_forced_align: lat=%0d err=%b want 4/0", lat, er); end
    do_req(1'b0, 12'h010, 2'b10, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL ram_forced_write: got %h want a5a5a5a5", rd); end
    do_req(1'b0, 12'h013, 2'b01, 1'b1, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000A5A5) begin errors++; $display("FAIL lhu_forced_align: got %h want 0000a5a5", rd); end
    do_req(1'b0, 12'h011, 2'b11, 1'b0, 32'h0, rd, er, lat);
    checks++; if (lat !== 4 || er !== 1'b0 || rd !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL size_reserved_as_word: lat=%0d err=%b rdata=%h want 4/0/a5a5a5a5", lat, er, rd);
    end
`endif
  endtask

  task automatic test_back_to_back;
    logic [31:0]   rd; logic er; int lat;
    logic [AW+1:0] addrs [3];
    logic [31:0]   vals  [3];
    int nacc, nrsp, cyc, last_rsp, ready_bad, gap_bad, data_bad, extra;
    addrs[0] = 12'h030; addrs[1] = 12'h034; addrs[2] = 12'h038;
    vals[0]  = 32'h0A0A0001; vals[1] = 32'hB0B0B002; vals[2] = 32'h0C0C0C03;
    for (int i = 0; i < 3; i++) do_req(1'b1, addrs[i], 2'b10, 1'b0, vals[i], rd, er, lat);
    nacc = 0; nrsp = 0; cyc = 0; last_rsp = 0; ready_bad = 0; gap_bad = 0; data_bad = 0; extra = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = addrs[0];
    while (nrsp < 3 && cyc < 100) begin
      if (bus.rsp_valid === 1'b1) begin
        if (nrsp < 3 && bus.rsp_rdata !== vals[nrsp]) data_bad++;
        if (nrsp > 0 && (cyc - last_rsp) != 5) gap_bad++;
        last_rsp = cyc;
        nrsp++;
      end
      if (bus.req_ready === bus.busy) ready_bad++;
      if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) nacc++;
      @(negedge clk);
      cyc++;
      if (nacc < 3) bus.req_addr = addrs[nacc];
      else          bus.req_valid = 1'b0;
    end
    repeat (8) begin
      if (bus.rsp_valid === 1'b1) extra++;
      @(negedge clk);
    end
    checks++; if (nacc !== 3) begin errors++; $display("FAIL b2b_accepts: got %0d want 3", nacc); end
    checks++; if (nrsp !== 3) begin errors++; $display("FAIL b2b_responses: got %0d want 3", nrsp); end
    checks++; if (data_bad !== 0) begin errors++; $display("FAIL b2b_data: got %0d bad want 0", data_bad); end
    checks++; if (gap_bad !== 0) begin errors++; $display("FAIL b2b_spacing: got %0d bad gaps want 0", gap_bad); end
    checks++; if (ready_bad !== 0) begin errors++; $display("FAIL b2b_ready_vs_busy: got %0d bad cycles want 0", ready_bad); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_extra_rsp: got %0d want 0", extra); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 12'h020, 2'b10, 1'b0, 32'hCAFEF00D, rd, er, lat);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 12'h020;
    bus.req_size = 2'b10; bus.req_wdata = 32'h11111111;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_in_flight: busy=%b want 1", bus.busy); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL abort_ready_busy: ready=%b busy=%b want 1/0", bus.req_ready, bus.busy);
    end
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
      errors++; $display("FAIL abort_rsp: valid=%b rdata=%h err=%b want 0/0/0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL abort_no_resume: valid=%b busy=%b want 0/0", bus.rsp_valid, bus.busy);
    end
    do_req(1'b0, 12'h020, 2'b10, 1'b0, 32'h0, rd, er, lat);
    checks++; if (lat !== 4 || rd !== 32'hCAFEF00D) begin
      errors++; $display("FAIL abort_ram_kept: lat=%0d rdata=%h want 4/cafef00d", lat, rd);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_align();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
